// File: rtl/nibble_alu_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | nibble_alu_sequencer_pkg                                                   |
// | Shared ALU command/control types, operand sizes and sequencer states.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package nibble_alu_sequencer_pkg;

   typedef enum logic [2:0] {
      ADD     = 3'd0,
      SUB     = 3'd1,
      RSHFT   = 3'd2,
      LSHFT   = 3'd3,
      BIT_AND = 3'd4,
      BIT_OR  = 3'd5,
      BIT_XOR = 3'd6,
      PASS    = 3'd7
   } AluCmd;

   typedef struct packed {
      AluCmd cmd;
      logic  carry_disable;
      logic  carry_in;
   } AluCtrl;

   typedef enum logic [1:0] {
      SIZE_8   = 2'b00,
      SIZE_16  = 2'b01,
      SIZE_32  = 2'b10,
      SIZE_32X = 2'b11
   } OpSize;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } SeqState;

   localparam logic [31:0] c_MASK_8  = 32'h0000_00FF;
   localparam logic [31:0] c_MASK_16 = 32'h0000_FFFF;
   localparam logic [31:0] c_MASK_32 = 32'hFFFF_FFFF;

   // The loop counts nibbles from N down to 0, so it is programmed with count-1.
   function automatic logic [2:0] size_to_nibbles(input OpSize size);
      case (size)
         SIZE_8:  return 3'd1;
         SIZE_16: return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [31:0] size_mask(input OpSize size);
      case (size)
         SIZE_8:  return c_MASK_8;
         SIZE_16: return c_MASK_16;
         default: return c_MASK_32;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_operand_prep.sv
// +----------------------------------------------------------------------------+
// | nibble_operand_prep                                                        |
// | Combinational derivation of masked word2, sign flag, nibble count, preinit.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nibble_operand_prep
   import nibble_alu_sequencer_pkg::*;
(
   input  OpSize       i_size,
   input  logic        i_signed,
   input  AluCmd       i_cmd,
   input  logic [31:0] i_word1,
   input  logic [31:0] i_word2,
   output logic [2:0]  o_nibbles_number,
   output logic [31:0] o_word2,
   output logic        o_word2_is_negative,
   output logic [31:0] o_preinit_result
);

   logic [31:0] w_word2;

   assign w_word2          = i_word2 & size_mask(i_size);
   assign o_word2          = w_word2;
   assign o_nibbles_number = size_to_nibbles(i_size);
   // Only ADD accumulates onto word1; every other command starts from zero.
   assign o_preinit_result = (i_cmd == ADD) ? i_word1 : 32'h0;

   always_comb begin
      o_word2_is_negative = 1'b0;
      case (i_size)
         SIZE_8:  o_word2_is_negative = i_signed & w_word2[7];
         SIZE_16: o_word2_is_negative = i_signed & w_word2[15];
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/nibble_alu_sequencer.sv
// +----------------------------------------------------------------------------+
// | nibble_alu_sequencer                                                       |
// | Command stage for the nibble-serial ALU loop; optional run timeout is      |
// | enabled by defining NIBBLE_SEQ_TIMEOUT_EN.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module nibble_alu_sequencer
   import nibble_alu_sequencer_pkg::*;
#(
   parameter int RUN_TIMEOUT = 12
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  AluCmd       in_cmd,
   input  logic [1:0]  in_size,
   input  logic        in_signed,
   input  logic        in_carry_disable,
   input  logic [31:0] in_word1,
   input  logic [31:0] in_word2,
   output logic        loop_perm_to_count,
   output logic [2:0]  loop_nibbles_number,
   output AluCmd       ctrl_cmd,
   output logic        ctrl_carry_disable,
   output logic        word2_is_negative,
   output logic [31:0] word1,
   output logic [31:0] word2,
   output logic [31:0] preinit_result,
   input  logic        loop_busy,
   input  logic [31:0] loop_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_error
);

   SeqState     r_state;
   SeqState     w_next_state;
   logic        r_run_first;
   logic        w_accept;
   logic        w_busy_done;
   logic        w_timeout;

   logic [2:0]  w_prep_nibbles;
   logic [31:0] w_prep_word2;
   logic        w_prep_negative;
   logic [31:0] w_prep_preinit;

   logic [2:0]  r_nibbles;
   AluCmd       r_cmd;
   logic        r_carry_disable;
   logic        r_negative;
   logic [31:0] r_word1;
   logic [31:0] r_word2;
   logic [31:0] r_preinit;
   logic [31:0] r_out_result;

   nibble_operand_prep u_prep (
      .i_size              (OpSize'(in_size)),
      .i_signed            (in_signed),
      .i_cmd               (in_cmd),
      .i_word1             (in_word1),
      .i_word2             (in_word2),
      .o_nibbles_number    (w_prep_nibbles),
      .o_word2             (w_prep_word2),
      .o_word2_is_negative (w_prep_negative),
      .o_preinit_result    (w_prep_preinit)
   );

   assign w_accept    = (r_state == IDLE) && in_valid;
   // loop_busy is meaningless in the first RUN cycle: the loop has only just left reset.
   assign w_busy_done = (r_state == RUN) && !r_run_first && !loop_busy;

`ifdef NIBBLE_SEQ_TIMEOUT_EN
   logic [3:0] r_run_cnt;
   logic       r_out_error;

   assign w_timeout = (r_state == RUN) && loop_busy &&
                      (r_run_cnt == 4'(RUN_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_cnt   <= 4'd0;
         r_out_error <= 1'b0;
      end else begin
         if (r_state == ARM)
            r_run_cnt <= 4'd0;
         else if (r_state == RUN)
            r_run_cnt <= r_run_cnt + 4'd1;
         if (w_busy_done)
            r_out_error <= 1'b0;
         else if (w_timeout)
            r_out_error <= 1'b1;
      end
   end

   assign out_error = r_out_error;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (RUN_TIMEOUT != 0);
   assign w_timeout        = 1'b0;
   assign out_error        = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next_state = ARM;
         ARM:     w_next_state = RUN;
         RUN:     if (w_busy_done || w_timeout) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_run_first <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_run_first <= (r_state == ARM);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nibbles       <= 3'd0;
         r_cmd           <= ADD;
         r_carry_disable <= 1'b0;
         r_negative      <= 1'b0;
         r_word1         <= 32'h0;
         r_word2         <= 32'h0;
         r_preinit       <= 32'h0;
      end else if (w_accept) begin
         r_nibbles       <= w_prep_nibbles;
         r_cmd           <= in_cmd;
         r_carry_disable <= in_carry_disable;
         r_negative      <= w_prep_negative;
         r_word1         <= in_word1;
         r_word2         <= w_prep_word2;
         r_preinit       <= w_prep_preinit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_out_result <= 32'h0;
      else if (w_busy_done)
         r_out_result <= loop_result;
      else if (w_timeout)
         r_out_result <= 32'h0;
   end

   // The loop keeps counting permission through DONE so its result holds.
   assign loop_perm_to_count  = (r_state == RUN) || (r_state == DONE);
   assign in_ready            = (r_state == IDLE);
   assign out_valid           = (r_state == DONE);
   assign out_result          = r_out_result;
   assign loop_nibbles_number = r_nibbles;
   assign ctrl_cmd            = r_cmd;
   assign ctrl_carry_disable  = r_carry_disable;
   assign word2_is_negative   = r_negative;
   assign word1               = r_word1;
   assign word2               = r_word2;
   assign preinit_result      = r_preinit;

endmodule

`default_nettype wire
